// File: rtl/tap_read_arbiter_n_pkg.sv
// Shared constants and types for the TAP read interconnect: IR encoding,
// channel addresses, the IDCODE value and the read FSM state type.
package tap_read_arbiter_n_pkg;

  localparam int IRLENGTH = 5;

  localparam logic [IRLENGTH-1:0] ADDR_IDCODE = 5'h01;
  localparam logic [IRLENGTH-1:0] ADDR_DMI    = 5'h11;
  localparam logic [IRLENGTH-1:0] ADDR_STB0_A = 5'h12;
  localparam logic [IRLENGTH-1:0] ADDR_STB0_D = 5'h13;
  localparam logic [IRLENGTH-1:0] ADDR_STB1_A = 5'h14;
  localparam logic [IRLENGTH-1:0] ADDR_STB1_D = 5'h15;

  localparam logic [31:0] IDCODEVALUE = 32'h1000_5A3D;

  typedef enum logic [1:0] {
    RD_IDLE,
    RD_WAIT,
    RD_HOLD
  } tap_rd_state_e;

  // Width of a channel index; never zero so a single channel still has a port.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/tap_read_arbiter_n_rr.sv
// Round-robin search: first set request strictly after ptr_i (wrapping),
// returned as a one-hot grant plus its index.
module rr_arbiter
  import tap_read_arbiter_n_pkg::*;
#(
  parameter int N  = 5,
  parameter int IW = idx_width(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  grant_o,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);

  always_comb begin
    int   j;
    logic found;
    // NOTE: every variable written here gets a default first, so no latch is inferred.
    grant_o = '0;
    idx_o   = '0;
    found   = 1'b0;
    j       = 0;
    for (int off = 1; off <= N; off++) begin
      j = int'(ptr_i) + off;
      if (j >= N) j = j - N;
      if (!found && req_i[j[IW-1:0]]) begin
        found               = 1'b1;
        grant_o[j[IW-1:0]]  = 1'b1;
        idx_o               = j[IW-1:0];
      end
    end
    any_o = found;
  end

endmodule

// File: rtl/tap_read_arbiter_n.sv
// N-channel TAP read interconnect: address-decoded valid/ready transfer with
// timeout, result held until accepted, plus round-robin pending-channel advertise.
module tap_read_arbiter_n
  import tap_read_arbiter_n_pkg::*;
#(
  parameter int                         NUM_CH         = 5,
  parameter int                         READ_WIDTH     = 41,
  parameter logic [NUM_CH*IRLENGTH-1:0] CH_ADDR        = {ADDR_STB1_D, ADDR_STB1_A,
                                                          ADDR_STB0_D, ADDR_STB0_A, ADDR_DMI},
  parameter int                         TIMEOUT_CYCLES = 1024
) (
  input  logic                         CLK_I,
  input  logic                         RST_NI,
  input  logic                         READ_REQ_I,
  input  logic [IRLENGTH-1:0]          READ_ADDRESS_I,
  output logic [READ_WIDTH-1:0]        READ_DATA_O,
  output logic                         READ_VALID_O,
  input  logic                         READ_READY_I,
  output logic                         READ_ERR_O,
  output logic                         READ_BUSY_O,
  output logic [IRLENGTH-1:0]          VALID_ADDRESS_O,
  output logic                         VALID_ANY_O,
  input  logic [NUM_CH-1:0]            CH_VALID_I,
  output logic [NUM_CH-1:0]            CH_READY_O,
  input  logic [NUM_CH*READ_WIDTH-1:0] CH_DATA_I
);

  localparam int             IW     = idx_width(NUM_CH);
  localparam int             TW     = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0]  T_LAST = TW'(TIMEOUT_CYCLES - 1);

  tap_rd_state_e         state_q, state_d;
  logic [IW-1:0]         sel_q, sel_d;
  logic [TW-1:0]         timer_q, timer_d;
  logic [READ_WIDTH-1:0] data_q, data_d;
  logic                  err_q, err_d;
  logic                  valid_q, valid_d;
  logic                  busy_q, busy_d;
  logic [IRLENGTH-1:0]   vaddr_q, vaddr_d;
  logic                  vany_q, vany_d;
  logic [IW-1:0]         ptr_q, ptr_d;

  logic                  hit;
  logic [IW-1:0]         hit_idx;
  logic [NUM_CH-1:0]     rr_grant;
  logic [IW-1:0]         rr_idx;
  logic                  rr_any;
  logic [IRLENGTH-1:0]   adv_addr;

  // Descending scan so the lowest matching index is the one left standing.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (READ_ADDRESS_I == CH_ADDR[i*IRLENGTH +: IRLENGTH]) begin
        hit     = 1'b1;
        hit_idx = IW'(i);
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    timer_d    = timer_q;
    data_d     = data_q;
    err_d      = err_q;
    CH_READY_O = '0;
    unique case (state_q)
      RD_IDLE: begin
        if (READ_REQ_I) begin
          if (hit) begin
            sel_d   = hit_idx;
            timer_d = '0;
            state_d = RD_WAIT;
          end else if (READ_ADDRESS_I == ADDR_IDCODE) begin
            data_d  = READ_WIDTH'(IDCODEVALUE);
            err_d   = 1'b0;
            state_d = RD_HOLD;
          end else begin
            data_d  = '0;
            err_d   = 1'b1;
            state_d = RD_HOLD;
          end
        end
      end
      RD_WAIT: begin
        // Ready mirrors the selected valid combinationally; a transfer beats a timeout.
        if (CH_VALID_I[sel_q]) begin
          CH_READY_O[sel_q] = 1'b1;
          data_d  = CH_DATA_I[int'(sel_q)*READ_WIDTH +: READ_WIDTH];
          err_d   = 1'b0;
          state_d = RD_HOLD;
        end else if (TIMEOUT_CYCLES != 0) begin
          if (timer_q == T_LAST) begin
            data_d  = '0;
            err_d   = 1'b1;
            state_d = RD_HOLD;
          end else begin
            timer_d = timer_q + TW'(1);
          end
        end
      end
      RD_HOLD: begin
        if (READ_READY_I) state_d = RD_IDLE;
      end
      default: state_d = RD_IDLE;
    endcase
    valid_d = (state_d == RD_HOLD);
    busy_d  = (state_d != RD_IDLE);
  end

  rr_arbiter #(.N(NUM_CH), .IW(IW)) u_rr (
    .req_i   (CH_VALID_I),
    .ptr_i   (ptr_q),
    .grant_o (rr_grant),
    .idx_o   (rr_idx),
    .any_o   (rr_any)
  );

  always_comb begin
    adv_addr = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (rr_grant[i]) adv_addr = adv_addr | CH_ADDR[i*IRLENGTH +: IRLENGTH];
    end
    vany_d  = rr_any;
    vaddr_d = rr_any ? adv_addr : vaddr_q;
    ptr_d   = rr_any ? rr_idx : ptr_q;
  end

  always_ff @(posedge CLK_I or negedge RST_NI) begin
    // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
    if (!RST_NI) begin
      state_q <= RD_IDLE;
      sel_q   <= '0;
      timer_q <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      vaddr_q <= '0;
      vany_q  <= 1'b0;
      ptr_q   <= IW'(NUM_CH - 1);
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      timer_q <= timer_d;
      data_q  <= data_d;
      err_q   <= err_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      vaddr_q <= vaddr_d;
      vany_q  <= vany_d;
      ptr_q   <= ptr_d;
    end
  end

  assign READ_DATA_O     = data_q;
  assign READ_ERR_O      = err_q;
  assign READ_VALID_O    = valid_q;
  assign READ_BUSY_O     = busy_q;
  assign VALID_ADDRESS_O = vaddr_q;
  assign VALID_ANY_O     = vany_q;

endmodule

// File: tb/tb_tap_read_arbiter_n.sv
// Directed bench for tap_read_arbiter_n (5 channels, 41-bit data, 8-cycle timeout).
module tb_tap_read_arbiter_n;

  localparam logic [4:0] A0   = 5'h11;
  localparam logic [4:0] A1   = 5'h12;
  localparam logic [4:0] A2   = 5'h13;
  localparam logic [4:0] A3   = 5'h14;
  localparam logic [4:0] A4   = 5'h15;
  localparam logic [4:0] AID  = 5'h01;
  localparam logic [4:0] AUNK = 5'h1F;
  localparam logic [40:0] IDC = 41'h000_1000_5A3D;

  logic         CLK_I = 1'b0;
  logic         RST_NI;
  logic         READ_REQ_I;
  logic [4:0]   READ_ADDRESS_I;
  logic [40:0]  READ_DATA_O;
  logic         READ_VALID_O;
  logic         READ_READY_I;
  logic         READ_ERR_O;
  logic         READ_BUSY_O;
  logic [4:0]   VALID_ADDRESS_O;
  logic         VALID_ANY_O;
  logic [4:0]   CH_VALID_I;
  logic [4:0]   CH_READY_O;
  logic [204:0] CH_DATA_I;

  int checks   = 0;
  int failures = 0;

  tap_read_arbiter_n #(.TIMEOUT_CYCLES(8)) dut (
    .CLK_I           (CLK_I),
    .RST_NI          (RST_NI),
    .READ_REQ_I      (READ_REQ_I),
    .READ_ADDRESS_I  (READ_ADDRESS_I),
    .READ_DATA_O     (READ_DATA_O),
    .READ_VALID_O    (READ_VALID_O),
    .READ_READY_I    (READ_READY_I),
    .READ_ERR_O      (READ_ERR_O),
    .READ_BUSY_O     (READ_BUSY_O),
    .VALID_ADDRESS_O (VALID_ADDRESS_O),
    .VALID_ANY_O     (VALID_ANY_O),
    .CH_VALID_I      (CH_VALID_I),
    .CH_READY_O      (CH_READY_O),
    .CH_DATA_I       (CH_DATA_I)
  );

  always #5 CLK_I = ~CLK_I;

  task automatic tick();
    @(posedge CLK_I);
    #2;
  endtask

  task automatic test_reset();
    RST_NI = 1'b0; READ_REQ_I = 1'b0; READ_ADDRESS_I = '0; READ_READY_I = 1'b0;
    CH_VALID_I = '0; CH_DATA_I = '0;
    repeat (2) @(posedge CLK_I);
    #2;
    checks++; if (READ_VALID_O !== 1'b0) begin failures++; $display("FAIL rst_valid got=%0h exp=0", READ_VALID_O); end
    checks++; if (READ_BUSY_O !== 1'b0) begin failures++; $display("FAIL rst_busy got=%0h exp=0", READ_BUSY_O); end
    checks++; if (READ_DATA_O !== 41'h0) begin failures++; $display("FAIL rst_data got=%0h exp=0", READ_DATA_O); end
    RST_NI = 1'b1;
    tick();
    READ_REQ_I = 1'b1; READ_ADDRESS_I = A1;
    tick();
    READ_REQ_I = 1'b0; CH_VALID_I = 5'b00010;
    #1;
    checks++; if (CH_READY_O !== 5'b00010) begin failures++; $display("FAIL rst_pre_ready got=%b exp=00010", CH_READY_O); end
    checks++; if (READ_BUSY_O !== 1'b1) begin failures++; $display("FAIL rst_pre_busy got=%0h exp=1", READ_BUSY_O); end
    RST_NI = 1'b0;
    #1;
    checks++; if (CH_READY_O !== 5'b00000) begin failures++; $display("FAIL rst_async_ready got=%b exp=00000", CH_READY_O); end
    checks++; if (READ_BUSY_O !== 1'b0) begin failures++; $display("FAIL rst_async_busy got=%0h exp=0", READ_BUSY_O); end
    CH_VALID_I = '0;
    #1;
    RST_NI = 1'b1;
    tick();
    checks++; if (READ_DATA_O !== 41'h0) begin failures++; $display("FAIL post_rst_data got=%0h exp=0", READ_DATA_O); end
    checks++; if (READ_VALID_O !== 1'b0) begin failures++; $display("FAIL post_rst_valid got=%0h exp=0", READ_VALID_O); end
    checks++; if (READ_ERR_O !== 1'b0) begin failures++; $display("FAIL post_rst_err got=%0h exp=0", READ_ERR_O); end
    checks++; if (READ_BUSY_O !== 1'b0) begin failures++; $display("FAIL post_rst_busy got=%0h exp=0", READ_BUSY_O); end
    checks++; if (VALID_ADDRESS_O !== 5'h0) begin failures++; $display("FAIL post_rst_vaddr got=%0h exp=0", VALID_ADDRESS_O); end
    checks++; if (VALID_ANY_O !== 1'b0) begin failures++; $display("FAIL post_rst_vany got=%0h exp=0", VALID_ANY_O); end
    checks++; if (CH_READY_O !== 5'b0) begin failures++; $display("FAIL post_rst_ready got=%b exp=00000", CH_READY_O); end
  endtask

  task automatic test_transfer();
    READ_REQ_I = 1'b1; READ_ADDRESS_I = A2; CH_VALID_I = 5'b00100;
    CH_DATA_I[2*41 +: 41] = 41'h1_2345_6789;
    #1;
    checks++; if (CH_READY_O !== 5'b00000) begin failures++; $display("FAIL xfer_c0_ready got=%b exp=00000", CH_READY_O); end
    tick();
    READ_REQ_I = 1'b0;
    #1;
    checks++; if (CH_READY_O !== 5'b00100) begin failures++; $display("FAIL xfer_c1_ready got=%b exp=00100", CH_READY_O); end
    checks++; if (READ_VALID_O !== 1'b0) begin failures++; $display("FAIL xfer_c1_valid got=%0h exp=0", READ_VALID_O); end
    tick();
    CH_VALID_I = '0;
    #1;
    checks++; if (CH_READY_O !== 5'b00000) begin failures++; $display("FAIL xfer_c2_ready got=%b exp=00000", CH_READY_O); end
    for (int c = 2; c <= 4; c++) begin
      checks++; if (READ_VALID_O !== 1'b1) begin failures++; $display("FAIL xfer_hold_valid c=%0d got=%0h exp=1", c, READ_VALID_O); end
      checks++; if (READ_DATA_O !== 41'h1_2345_6789) begin failures++; $display("FAIL xfer_hold_data c=%0d got=%0h exp=123456789", c, READ_DATA_O); end
      checks++; if (READ_ERR_O !== 1'b0) begin failures++; $display("FAIL xfer_hold_err c=%0d got=%0h exp=0", c, READ_ERR_O); end
      if (c == 4) READ_READY_I = 1'b1;
      tick();
    end
    READ_READY_I = 1'b0;
    checks++; if (READ_VALID_O !== 1'b0) begin failures++; $display("FAIL xfer_done_valid got=%0h exp=0", READ_VALID_O); end
    checks++; if (READ_BUSY_O !== 1'b0) begin failures++; $display("FAIL xfer_done_busy got=%0h exp=0", READ_BUSY_O); end
  endtask

  task automatic test_idcode_unknown();
    READ_REQ_I = 1'b1; READ_ADDRESS_I = AID;
    tick();
    READ_REQ_I = 1'b0;
    checks++; if (READ_VALID_O !== 1'b1) begin failures++; $display("FAIL idc_valid got=%0h exp=1", READ_VALID_O); end
    checks++; if (READ_DATA_O !== IDC) begin failures++; $display("FAIL idc_data got=%0h exp=%0h", READ_DATA_O, IDC); end
    checks++; if (READ_ERR_O !== 1'b0) begin failures++; $display("FAIL idc_err got=%0h exp=0", READ_ERR_O); end
    READ_READY_I = 1'b1;
    tick();
    READ_READY_I = 1'b0;
    checks++; if (READ_VALID_O !== 1'b0) begin failures++; $display("FAIL idc_done_valid got=%0h exp=0", READ_VALID_O); end
    READ_REQ_I = 1'b1; READ_ADDRESS_I = AUNK; CH_VALID_I = 5'b11111;
    #1;
    checks++; if (CH_READY_O !== 5'b0) begin failures++; $display("FAIL unk_c0_ready got=%b exp=00000", CH_READY_O); end
    tick();
    READ_REQ_I = 1'b0;
    #1;
    checks++; if (READ_VALID_O !== 1'b1) begin failures++; $display("FAIL unk_valid got=%0h exp=1", READ_VALID_O); end
    checks++; if (READ_DATA_O !== 41'h0) begin failures++; $display("FAIL unk_data got=%0h exp=0", READ_DATA_O); end
    checks++; if (READ_ERR_O !== 1'b1) begin failures++; $display("FAIL unk_err got=%0h exp=1", READ_ERR_O); end
    checks++; if (CH_READY_O !== 5'b0) begin failures++; $display("FAIL unk_c1_ready got=%b exp=00000", CH_READY_O); end
    READ_READY_I = 1'b1;
    tick();
    READ_READY_I = 1'b0; CH_VALID_I = '0;
    checks++; if (READ_VALID_O !== 1'b0) begin failures++; $display("FAIL unk_done_valid got=%0h exp=0", READ_VALID_O); end
  endtask

  task automatic test_timeout();
    // Valid arriving on the terminal WAIT cycle still transfers.
    READ_REQ_I = 1'b1; READ_ADDRESS_I = A3; CH_VALID_I = '0;
    CH_DATA_I[3*41 +: 41] = 41'h155_AAAA_0000;
    tick();
    READ_REQ_I = 1'b0;
    for (int c = 1; c <= 7; c++) begin
      checks++; if (READ_VALID_O !== 1'b0 || CH_READY_O !== 5'b0) begin failures++; $display("FAIL tterm_wait c=%0d valid=%0h ready=%b exp=0/00000", c, READ_VALID_O, CH_READY_O); end
      tick();
    end
    CH_VALID_I = 5'b01000;
    #1;
    checks++; if (CH_READY_O !== 5'b01000) begin failures++; $display("FAIL tterm_ready got=%b exp=01000", CH_READY_O); end
    tick();
    CH_VALID_I = '0;
    checks++; if (READ_VALID_O !== 1'b1) begin failures++; $display("FAIL tterm_valid got=%0h exp=1", READ_VALID_O); end
    checks++; if (READ_DATA_O !== 41'h155_AAAA_0000) begin failures++; $display("FAIL tterm_data got=%0h exp=155aaaa0000", READ_DATA_O); end
    checks++; if (READ_ERR_O !== 1'b0) begin failures++; $display("FAIL tterm_err got=%0h exp=0", READ_ERR_O); end
    READ_READY_I = 1'b1;
    tick();
    READ_READY_I = 1'b0;
    // Channel never valid: abort exactly 9 cycles after the request.
    READ_REQ_I = 1'b1; READ_ADDRESS_I = A4;
    tick();
    READ_REQ_I = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      checks++; if (READ_VALID_O !== 1'b0 || READ_BUSY_O !== 1'b1) begin failures++; $display("FAIL tout_wait c=%0d valid=%0h busy=%0h exp=0/1", c, READ_VALID_O, READ_BUSY_O); end
      tick();
    end
    checks++; if (READ_VALID_O !== 1'b1) begin failures++; $display("FAIL tout_valid got=%0h exp=1", READ_VALID_O); end
    checks++; if (READ_ERR_O !== 1'b1) begin failures++; $display("FAIL tout_err got=%0h exp=1", READ_ERR_O); end
    checks++; if (READ_DATA_O !== 41'h0) begin failures++; $display("FAIL tout_data got=%0h exp=0", READ_DATA_O); end
    READ_READY_I = 1'b1;
    tick();
    READ_READY_I = 1'b0;
  endtask

  task automatic test_advertise();
    logic [4:0] exp_addr [4];
    exp_addr[0] = A0; exp_addr[1] = A2; exp_addr[2] = A0; exp_addr[3] = A2;
    RST_NI = 1'b0; CH_VALID_I = 5'b00101;
    #1;
    RST_NI = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      checks++; if (VALID_ADDRESS_O !== exp_addr[c]) begin failures++; $display("FAIL adv_addr c=%0d got=%0h exp=%0h", c, VALID_ADDRESS_O, exp_addr[c]); end
      checks++; if (VALID_ANY_O !== 1'b1) begin failures++; $display("FAIL adv_any c=%0d got=%0h exp=1", c, VALID_ANY_O); end
    end
    CH_VALID_I = '0;
    for (int c = 0; c < 2; c++) begin
      tick();
      checks++; if (VALID_ANY_O !== 1'b0) begin failures++; $display("FAIL adv_idle_any c=%0d got=%0h exp=0", c, VALID_ANY_O); end
      checks++; if (VALID_ADDRESS_O !== A2) begin failures++; $display("FAIL adv_idle_addr c=%0d got=%0h exp=%0h", c, VALID_ADDRESS_O, A2); end
    end
  endtask

  task automatic test_ignore();
    READ_REQ_I = 1'b1; READ_ADDRESS_I = A0; CH_VALID_I = '0;
    CH_DATA_I[0 +: 41] = 41'h0AB_CDEF_0123;
    tick();
    READ_ADDRESS_I = AID;
    for (int c = 1; c <= 2; c++) begin
      #1;
      checks++; if (READ_BUSY_O !== 1'b1 || READ_VALID_O !== 1'b0 || CH_READY_O !== 5'b0) begin failures++; $display("FAIL ign_wait c=%0d busy=%0h valid=%0h ready=%b exp=1/0/00000", c, READ_BUSY_O, READ_VALID_O, CH_READY_O); end
      tick();
    end
    CH_VALID_I = 5'b00001; READ_ADDRESS_I = A1;
    #1;
    checks++; if (CH_READY_O !== 5'b00001) begin failures++; $display("FAIL ign_ready got=%b exp=00001", CH_READY_O); end
    tick();
    CH_VALID_I = '0;
    for (int c = 0; c < 2; c++) begin
      checks++; if (READ_VALID_O !== 1'b1 || READ_DATA_O !== 41'h0AB_CDEF_0123 || READ_ERR_O !== 1'b0) begin failures++; $display("FAIL ign_hold c=%0d valid=%0h data=%0h err=%0h exp=1/abcdef0123/0", c, READ_VALID_O, READ_DATA_O, READ_ERR_O); end
      tick();
    end
    READ_REQ_I = 1'b0; READ_READY_I = 1'b1;
    for (int c = 0; c < 2; c++) begin
      tick();
      checks++; if (READ_VALID_O !== 1'b0 || READ_BUSY_O !== 1'b0 || CH_READY_O !== 5'b0) begin failures++; $display("FAIL ign_idle c=%0d valid=%0h busy=%0h ready=%b exp=0/0/00000", c, READ_VALID_O, READ_BUSY_O, CH_READY_O); end
    end
    READ_READY_I = 1'b0;
  endtask

  initial begin
    test_reset();
    test_transfer();
    test_idcode_unknown();
    test_timeout();
    test_advertise();
    test_ignore();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
